rftpu_result_drain: RTL and testbench
=====================================

// Module: rftpu_result_drain
// PURPOSE
//  Downstream stage of the RFTPU systolic array. It accepts one ARRAY_DIM-lane accumulator row per
//  in_valid, then runs it through: fixed-point scale -> round -> shift -> optional ReLU -> saturate to int8.
//  It writes the packed row into the unified buffer at an auto-incrementing address.
//  A small FIFO absorbs array bursts, because the array has no backpressure.
// PARAMETERS
//  ARRAY_DIM    16   lanes per row
//  ACC_WIDTH    32   signed accumulator width per lane
//  DATA_WIDTH   8    signed output width per lane
//  SCALE_WIDTH  16   signed requant multiplier width
//  FIFO_DEPTH   4    input row FIFO entries (power of 2, >=2)
//  UB_DEPTH     256  unified buffer rows; the address wraps modulo UB_DEPTH
// PORTS
//  clk            in   1                      clock, all logic on rising edge
//  rst            in   1                      synchronous, active-high reset
//  cfg_start      in   1                      start job (honoured in IDLE only)
//  cfg_base_addr  in   $clog2(UB_DEPTH)       first write address
//  cfg_num_rows   in   16                     rows to write this job
//  cfg_scale      in   SCALE_WIDTH            signed multiplier
//  cfg_shift      in   6                      right shift, 0..47
//  cfg_relu       in   1                      clamp negatives to 0
//  in_valid       in   1                      result row present (no ready)
//  in_data        in   ARRAY_DIM*ACC_WIDTH    lane i at [i*ACC_WIDTH +: ACC_WIDTH]
//  ub_wr_en       out  1                      write request (valid)
//  ub_wr_ready    in   1                      buffer accepts the write this cycle
//  ub_wr_addr     out  $clog2(UB_DEPTH)       write address
//  ub_wr_data     out  ARRAY_DIM*DATA_WIDTH   packed int8 row
//  busy           out  1                      job active
//  done           out  1                      1-cycle pulse at job end
//  overflow_err   out  1                      sticky: a row was dropped
//  sat_count      out  32                     lanes saturated this job
// BEHAVIOUR
//  - Reset: all outputs 0, FIFO emptied, pipeline valids cleared, state IDLE. Applies mid-job too;
//    in-flight rows are discarded.
//  - FSM IDLE -> RUN on cfg_start. At start, latch all cfg_*; clear overflow_err and sat_count; wr_addr = base.
//    - cfg_num_rows == 0: IDLE -> DONE -> IDLE. done pulses the cycle after start; no writes.
//    - RUN -> DONE once the cfg_num_rows-th write handshake completes. done is high 1 cycle in DONE, then IDLE.
//    - cfg_start outside IDLE is ignored.
//  - Intake (RUN only; in_valid in IDLE/DONE is ignored):
//    - push when in_valid && (!full || pop same cycle).
//    - in_valid with FIFO full and no pop: row dropped, overflow_err <= 1.
//  - Pipeline, each stage with its own valid; whole pipe stalls when S3 valid && !ub_wr_ready:
//    - S1: pop FIFO. prod = signed(acc) * signed(scale), ACC_WIDTH+SCALE_WIDTH bits.
//    - S2: r = (prod + (shift ? 1<<(shift-1) : 0)) >>> shift. Arithmetic shift, round half toward +inf.
//    - S3: if relu and r<0 then r=0. Saturate to [-128,127]; sat_count += lanes clipped.
//      S3 is the output register: ub_wr_en = S3 valid.
//  - Latency: row pushed at edge N gives ub_wr_en high after edge N+3 when unstalled. Throughput 1 row/cycle.
//  - Handshake: a write completes when ub_wr_en && ub_wr_ready. ub_wr_addr/ub_wr_data stay stable while
//    waiting. wr_addr increments per completed write and wraps UB_DEPTH-1 -> 0.
//  - Buffering under stall: FIFO_DEPTH + 3 rows.
//  - Rows arriving after cfg_num_rows writes are ignored.
//  - busy = (state != IDLE).
// TESTING
//  1. scale=1, shift=0, relu=0: lanes 100,-5,300,-300 -> 100,-5,127,-128 at ub_wr_addr=base; sat_count=2.
//  2. scale=3, shift=2: acc 5 -> (15+2)>>>2 = 4; acc -5 -> (-15+2)>>>2 = -4. Same with relu=1 -> 4, 0.
//  3. base=254, num_rows=4, ready=1, 4 back-to-back rows -> addrs 254,255,0,1. done one cycle after 4th write.
//  4. ready=0, 9 consecutive rows, FIFO_DEPTH=4, num_rows=7 -> overflow_err=1. After ready=1: exactly
//     rows 0-6 written in order, done pulses; rows 7-8 absent.
//  5. ready toggled every cycle during 5 rows -> data/addr held while unacked; 5 writes, no loss, no dup.
//  6. rst asserted 1 cycle while 2 rows in flight -> next cycle ub_wr_en=0, busy=0, sat_count=0.
//     A new job then writes from its own base.

Source files
------------

// File: rtl/rftpu_result_drain_if.sv
// Unified-buffer write port of the result drain: valid/ready write with address and packed int8 row.
interface rftpu_result_drain_if #(
  parameter int ARRAY_DIM  = 16,
  parameter int DATA_WIDTH = 8,
  parameter int UB_DEPTH   = 256
);
  logic                            ub_wr_en;
  logic                            ub_wr_ready;
  logic [$clog2(UB_DEPTH)-1:0]     ub_wr_addr;
  logic [ARRAY_DIM*DATA_WIDTH-1:0] ub_wr_data;

  modport master (
    output ub_wr_en,
    output ub_wr_addr,
    output ub_wr_data,
    input  ub_wr_ready
  );

  modport slave (
    input  ub_wr_en,
    input  ub_wr_addr,
    input  ub_wr_data,
    output ub_wr_ready
  );
endinterface

// File: rtl/rftpu_result_drain.sv
// Result drain for the RFTPU systolic array: buffers accumulator rows in a small FIFO, requantises
// each lane (scale, round, shift, optional ReLU, int8 saturate) and writes rows to the unified buffer.
module rftpu_result_drain #(
  parameter int ARRAY_DIM   = 16,
  parameter int ACC_WIDTH   = 32,
  parameter int DATA_WIDTH  = 8,
  parameter int SCALE_WIDTH = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int UB_DEPTH    = 256
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cfg_start,
  input  logic [$clog2(UB_DEPTH)-1:0]       cfg_base_addr,
  input  logic [15:0]                       cfg_num_rows,
  input  logic signed [SCALE_WIDTH-1:0]     cfg_scale,
  input  logic [5:0]                        cfg_shift,
  input  logic                              cfg_relu,
  input  logic                              in_valid,
  input  logic [ARRAY_DIM*ACC_WIDTH-1:0]    in_data,
  rftpu_result_drain_if.master              ub,
  output logic                              busy,
  output logic                              done,
  output logic                              overflow_err,
  output logic [31:0]                       sat_count
);
  localparam int AW    = $clog2(UB_DEPTH);
  localparam int FAW   = $clog2(FIFO_DEPTH);
  localparam int PW    = ACC_WIDTH + SCALE_WIDTH;
  localparam int RW    = PW + 1;
  localparam int ROW_W = ARRAY_DIM * ACC_WIDTH;
  localparam int OUT_W = ARRAY_DIM * DATA_WIDTH;

  localparam logic signed [RW-1:0] SAT_MAX   = RW'((2 ** (DATA_WIDTH - 1)) - 1);
  localparam logic signed [RW-1:0] SAT_MIN   = RW'(-(2 ** (DATA_WIDTH - 1)));
  localparam logic [FAW:0]         FIFO_FULL = (FAW + 1)'(FIFO_DEPTH);
  localparam logic [AW-1:0]        ADDR_LAST = AW'(UB_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_next;

  logic [15:0]                   num_rows_q;
  logic [15:0]                   wr_count;
  logic signed [SCALE_WIDTH-1:0] scale_q;
  logic [5:0]                    shift_q;
  logic                          relu_q;
  logic [AW-1:0]                 wr_addr;

  logic [ROW_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [FAW-1:0]   fifo_wr_ptr, fifo_rd_ptr;
  logic [FAW:0]     fifo_count;
  logic [ROW_W-1:0] fifo_head;

  logic                 s1_valid, s2_valid, s3_valid;
  logic signed [PW-1:0] prod_next [ARRAY_DIM];
  logic signed [PW-1:0] s1_prod   [ARRAY_DIM];
  logic signed [RW-1:0] round_inc;
  logic signed [RW-1:0] r_next    [ARRAY_DIM];
  logic signed [RW-1:0] s2_r      [ARRAY_DIM];
  logic signed [RW-1:0] lane_val;
  logic [OUT_W-1:0]     s3_data_next;
  logic [31:0]          s3_clip_next;
  logic [OUT_W-1:0]     s3_data;

  logic run, stall, pop, push, drop, wr_fire, last_write;

  // The whole pipe freezes while the output row waits for the buffer; nothing moves outside RUN.
  assign run        = (state == RUN);
  assign stall      = s3_valid && !ub.ub_wr_ready;
  assign pop        = run && (fifo_count != '0) && !stall;
  assign push       = run && in_valid && ((fifo_count != FIFO_FULL) || pop);
  assign drop       = run && in_valid && (fifo_count == FIFO_FULL) && !pop;
  assign wr_fire    = run && s3_valid && ub.ub_wr_ready;
  assign last_write = wr_fire && (wr_count == num_rows_q - 16'd1);
  assign fifo_head  = fifo_mem[fifo_rd_ptr];

  assign ub.ub_wr_addr = wr_addr;
  assign ub.ub_wr_data = s3_data;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: a zero-row job goes straight to DONE so done still pulses.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cfg_start) state_next = (cfg_num_rows == 16'd0) ? DONE : RUN;
      RUN:     if (last_write) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode; the write request is only exposed while the job is running.
  always_comb begin
    busy        = (state != IDLE);
    done        = (state == DONE);
    ub.ub_wr_en = run && s3_valid;
  end

  // Job configuration, write address/count and the sticky status counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      num_rows_q   <= '0;
      scale_q      <= '0;
      shift_q      <= '0;
      relu_q       <= 1'b0;
      wr_addr      <= '0;
      wr_count     <= '0;
      overflow_err <= 1'b0;
      sat_count    <= '0;
    end else if (state == IDLE && cfg_start) begin
      num_rows_q   <= cfg_num_rows;
      scale_q      <= cfg_scale;
      shift_q      <= cfg_shift;
      relu_q       <= cfg_relu;
      wr_addr      <= cfg_base_addr;
      wr_count     <= '0;
      overflow_err <= 1'b0;
      sat_count    <= '0;
    end else begin
      if (drop) overflow_err <= 1'b1;
      if (wr_fire) begin
        wr_addr  <= (wr_addr == ADDR_LAST) ? '0 : wr_addr + AW'(1);
        wr_count <= wr_count + 16'd1;
      end
      if (run && !stall && s2_valid) sat_count <= sat_count + s3_clip_next;
    end
  end

  // FIFO pointers and occupancy; emptied whenever no job is running so leftovers never leak.
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      fifo_wr_ptr <= '0;
      fifo_rd_ptr <= '0;
      fifo_count  <= '0;
    end else begin
      if (push) fifo_wr_ptr <= fifo_wr_ptr + FAW'(1);
      if (pop)  fifo_rd_ptr <= fifo_rd_ptr + FAW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (FAW + 1)'(1);
        2'b01:   fifo_count <= fifo_count - (FAW + 1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FIFO storage, written on accepted rows only.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[fifo_wr_ptr] <= in_data;
  end

  // S1 datapath: full-width signed product per lane.
  always_comb begin
    for (int i = 0; i < ARRAY_DIM; i++) begin
      prod_next[i] = PW'($signed(fifo_head[i*ACC_WIDTH +: ACC_WIDTH])) * PW'(scale_q);
    end
  end

  // S2 datapath: add half an LSB then arithmetic shift; one extra bit keeps the rounding add exact.
  always_comb begin
    round_inc = (shift_q == 6'd0) ? '0 : (RW'(1) << (shift_q - 6'd1));
    for (int i = 0; i < ARRAY_DIM; i++) begin
      r_next[i] = (RW'(s1_prod[i]) + round_inc) >>> shift_q;
    end
  end

  // S3 datapath: optional ReLU, clamp to the int8 range and count clipped lanes.
  always_comb begin
    s3_data_next = '0;
    s3_clip_next = '0;
    lane_val     = '0;
    for (int i = 0; i < ARRAY_DIM; i++) begin
      lane_val = s2_r[i];
      if (relu_q && lane_val[RW-1]) lane_val = '0;
      if (lane_val > SAT_MAX) begin
        s3_data_next[i*DATA_WIDTH +: DATA_WIDTH] = SAT_MAX[DATA_WIDTH-1:0];
        s3_clip_next = s3_clip_next + 32'd1;
      end else if (lane_val < SAT_MIN) begin
        s3_data_next[i*DATA_WIDTH +: DATA_WIDTH] = SAT_MIN[DATA_WIDTH-1:0];
        s3_clip_next = s3_clip_next + 32'd1;
      end else begin
        s3_data_next[i*DATA_WIDTH +: DATA_WIDTH] = lane_val[DATA_WIDTH-1:0];
      end
    end
  end

  // Stage valids advance together and are cleared outside RUN to discard in-flight rows.
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else if (!stall) begin
      s1_valid <= pop;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
    end
  end

  // Intermediate stage data; only meaningful alongside its valid, so no reset.
  always_ff @(posedge clk) begin
    if (run && !stall) begin
      for (int i = 0; i < ARRAY_DIM; i++) begin
        s1_prod[i] <= prod_next[i];
        s2_r[i]    <= r_next[i];
      end
    end
  end

  // Output row register, held while the buffer withholds ready.
  always_ff @(posedge clk) begin
    if (rst)                s3_data <= '0;
    else if (run && !stall) s3_data <= s3_data_next;
  end
endmodule

// File: tb/tb_rftpu_result_drain.sv
// Self-checking bench for rftpu_result_drain: scoreboard of expected buffer writes built from a
// reference requantisation model, checked as the DUT completes each write handshake.
module tb_rftpu_result_drain;
  localparam int ARRAY_DIM = 16;
  localparam int ACC_WIDTH = 32;
  localparam int DATA_WIDTH = 8;
  localparam int SCALE_WIDTH = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int UB_DEPTH = 256;
  localparam int AW = 8;
  localparam int ROW_W = ARRAY_DIM * ACC_WIDTH;
  localparam int OUT_W = ARRAY_DIM * DATA_WIDTH;

  logic                          clk;
  logic                          rst;
  logic                          cfg_start;
  logic [AW-1:0]                 cfg_base_addr;
  logic [15:0]                   cfg_num_rows;
  logic signed [SCALE_WIDTH-1:0] cfg_scale;
  logic [5:0]                    cfg_shift;
  logic                          cfg_relu;
  logic                          in_valid;
  logic [ROW_W-1:0]              in_data;
  logic                          busy;
  logic                          done;
  logic                          overflow_err;
  logic [31:0]                   sat_count;

  rftpu_result_drain_if #(.ARRAY_DIM(ARRAY_DIM), .DATA_WIDTH(DATA_WIDTH), .UB_DEPTH(UB_DEPTH)) ub_if ();

  rftpu_result_drain #(
    .ARRAY_DIM(ARRAY_DIM), .ACC_WIDTH(ACC_WIDTH), .DATA_WIDTH(DATA_WIDTH),
    .SCALE_WIDTH(SCALE_WIDTH), .FIFO_DEPTH(FIFO_DEPTH), .UB_DEPTH(UB_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_base_addr(cfg_base_addr),
    .cfg_num_rows(cfg_num_rows), .cfg_scale(cfg_scale), .cfg_shift(cfg_shift),
    .cfg_relu(cfg_relu), .in_valid(in_valid), .in_data(in_data), .ub(ub_if.master),
    .busy(busy), .done(done), .overflow_err(overflow_err), .sat_count(sat_count)
  );

  typedef struct {
    logic [AW-1:0]    addr;
    logic [OUT_W-1:0] data;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail = 0;
  int cycle = 0;
  int done_count = 0;
  int done_base = 0;
  int done_cycle = 0;
  int last_fire_cycle = 0;
  int job_writes = 0;
  int job_base = 0;
  int job_scale = 0;
  int job_shift = 0;
  bit job_relu = 0;
  int job_idx = 0;
  int exp_sat = 0;

  logic             hold_pending = 1'b0;
  logic [AW-1:0]    hold_addr = '0;
  logic [OUT_W-1:0] hold_data = '0;
  logic             prev_done = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [OUT_W-1:0] actual, input logic [OUT_W-1:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Reference requantisation of a single lane.
  function automatic logic [7:0] modelLane(input longint acc, input longint scale, input int shift,
                                           input bit relu, output bit clipped);
    longint p;
    p = acc * scale;
    if (shift > 0) p = p + (longint'(1) << (shift - 1));
    p = p >>> shift;
    if (relu && p < 0) p = 0;
    clipped = 1'b0;
    if (p > 127) begin
      clipped = 1'b1;
      p = 127;
    end else if (p < -128) begin
      clipped = 1'b1;
      p = -128;
    end
    return p[7:0];
  endfunction

  function automatic logic [ROW_W-1:0] rowOf4(input int a, input int b, input int c, input int d);
    logic [ROW_W-1:0] r;
    r = '0;
    r[31:0] = a;
    r[63:32] = b;
    r[95:64] = c;
    r[127:96] = d;
    return r;
  endfunction

  function automatic logic [ROW_W-1:0] randomRow();
    logic [ROW_W-1:0] r;
    int v;
    for (int i = 0; i < ARRAY_DIM; i++) begin
      if (i % 2 == 1) v = int'($urandom);
      else v = int'($urandom_range(0, 2000)) - 1000;
      r[i*ACC_WIDTH +: ACC_WIDTH] = v;
    end
    return r;
  endfunction

  // Push the expected buffer write for a row into the scoreboard.
  task automatic expectRow(input logic [ROW_W-1:0] row);
    exp_t e;
    bit clipped;
    e.addr = AW'((job_base + job_idx) % UB_DEPTH);
    e.data = '0;
    for (int i = 0; i < ARRAY_DIM; i++) begin
      e.data[i*DATA_WIDTH +: DATA_WIDTH] =
        modelLane(longint'($signed(row[i*ACC_WIDTH +: ACC_WIDTH])), longint'(job_scale), job_shift, job_relu, clipped);
      if (clipped) exp_sat++;
    end
    sb.push_back(e);
    job_idx++;
  endtask

  // Drive one row for one cycle; expect_write says whether it should reach the buffer.
  task automatic applyStimulus(input logic [ROW_W-1:0] row, input bit expect_write);
    in_data = row;
    in_valid = 1'b1;
    if (expect_write) expectRow(row);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Start a job and scramble the cfg inputs afterwards so latching is exercised.
  task automatic startJob(input int base, input int rows, input int scale, input int shift, input bit relu);
    cfg_base_addr = base[AW-1:0];
    cfg_num_rows = rows[15:0];
    cfg_scale = scale[15:0];
    cfg_shift = shift[5:0];
    cfg_relu = relu;
    cfg_start = 1'b1;
    job_base = base;
    job_scale = scale;
    job_shift = shift;
    job_relu = relu;
    job_idx = 0;
    exp_sat = 0;
    job_writes = 0;
    done_base = done_count;
    @(posedge clk);
    #1;
    cfg_start = 1'b0;
    cfg_base_addr = ~cfg_base_addr;
    cfg_num_rows = 16'd999;
    cfg_scale = 16'sh1234;
    cfg_shift = 6'd3;
    cfg_relu = ~relu;
  endtask

  task automatic waitDone(input int budget, input string tag);
    for (int c = 0; c < budget; c++) begin
      if (done_count > done_base) break;
      @(posedge clk);
      #1;
    end
    checkOutput(tag, done_count > done_base, 1'b1);
    @(negedge clk);
    checkOutput({tag, "_busy"}, busy, 1'b0);
    @(posedge clk);
    #1;
  endtask

  // Write monitor: checks held data while stalled and pops the scoreboard on each completed write.
  always @(negedge clk) begin
    if (rst) begin
      hold_pending = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (hold_pending) begin
        checkOutput("hold_en", ub_if.ub_wr_en, 1'b1);
        checkOutput("hold_addr", ub_if.ub_wr_addr, hold_addr);
        checkOutput("hold_data", ub_if.ub_wr_data, hold_data);
      end
      if (done) begin
        checkOutput("done_width", prev_done, 1'b0);
        done_count++;
        done_cycle = cycle;
      end
      prev_done = done;
      if (ub_if.ub_wr_en && ub_if.ub_wr_ready) begin
        if (sb.size() == 0) begin
          checkOutput("write_expected", sb.size(), 1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("wr_addr", ub_if.ub_wr_addr, e.addr);
          checkOutput("wr_data", ub_if.ub_wr_data, e.data);
        end
        job_writes++;
        last_fire_cycle = cycle;
      end
      hold_pending = ub_if.ub_wr_en && !ub_if.ub_wr_ready;
      hold_addr = ub_if.ub_wr_addr;
      hold_data = ub_if.ub_wr_data;
    end
  end

  initial begin
    rst = 1'b1;
    cfg_start = 1'b0;
    cfg_base_addr = '0;
    cfg_num_rows = '0;
    cfg_scale = '0;
    cfg_shift = '0;
    cfg_relu = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    ub_if.ub_wr_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_wr_en", ub_if.ub_wr_en, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_overflow", overflow_err, 1'b0);
    checkOutput("rst_sat", sat_count, 0);
    checkOutput("rst_addr", ub_if.ub_wr_addr, 0);
    checkOutput("rst_data", ub_if.ub_wr_data, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] basic saturation");
    startJob(10, 1, 1, 0, 0);
    applyStimulus(rowOf4(100, -5, 300, -300), 1'b1);
    waitDone(20, "t1_done");
    checkOutput("t1_sat", sat_count, exp_sat);
    checkOutput("t1_writes", job_writes, 1);

    $display("[TB] scale, round and shift");
    startJob(20, 2, 3, 2, 0);
    applyStimulus(rowOf4(5, -5, 7, -7), 1'b1);
    applyStimulus(randomRow(), 1'b1);
    waitDone(20, "t2a_done");
    checkOutput("t2a_sat", sat_count, exp_sat);
    startJob(22, 1, 3, 2, 1);
    applyStimulus(rowOf4(5, -5, 2, -2), 1'b1);
    waitDone(20, "t2b_done");
    checkOutput("t2b_writes", job_writes, 1);

    $display("[TB] zero-row job");
    startJob(30, 0, 1, 0, 0);
    @(negedge clk);
    checkOutput("t0_done_now", done, 1'b1);
    @(posedge clk);
    #1;
    waitDone(5, "t0_done");
    checkOutput("t0_writes", job_writes, 0);

    $display("[TB] address wrap");
    startJob(254, 4, 7, 5, 0);
    for (int k = 0; k < 4; k++) applyStimulus(randomRow(), 1'b1);
    waitDone(30, "t3_done");
    checkOutput("t3_done_lat", done_cycle - last_fire_cycle, 1);
    checkOutput("t3_writes", job_writes, 4);
    checkOutput("t3_sat", sat_count, exp_sat);

    $display("[TB] overflow under stall");
    ub_if.ub_wr_ready = 1'b0;
    startJob(40, 7, 1, 0, 0);
    for (int k = 0; k < 9; k++) applyStimulus(randomRow(), k < 7);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    checkOutput("t4_overflow", overflow_err, 1'b1);
    @(posedge clk);
    #1;
    ub_if.ub_wr_ready = 1'b1;
    waitDone(60, "t4_done");
    repeat (5) @(posedge clk);
    #1;
    checkOutput("t4_writes", job_writes, 7);
    checkOutput("t4_sat", sat_count, exp_sat);
    checkOutput("t4_overflow_sticky", overflow_err, 1'b1);

    $display("[TB] toggling ready");
    startJob(60, 5, 2, 1, 1);
    @(negedge clk);
    checkOutput("t5_overflow_cleared", overflow_err, 1'b0);
    checkOutput("t5_sat_cleared", sat_count, 0);
    @(posedge clk);
    #1;
    fork
      begin
        for (int k = 0; k < 5; k++) applyStimulus(randomRow(), 1'b1);
      end
      begin
        repeat (25) begin
          ub_if.ub_wr_ready = ~ub_if.ub_wr_ready;
          @(posedge clk);
          #1;
        end
        ub_if.ub_wr_ready = 1'b1;
      end
    join
    waitDone(60, "t5_done");
    checkOutput("t5_writes", job_writes, 5);
    checkOutput("t5_sat", sat_count, exp_sat);

    $display("[TB] reset mid-job");
    ub_if.ub_wr_ready = 1'b0;
    startJob(80, 4, 1, 0, 0);
    applyStimulus(rowOf4(1000, -1000, 5, 6), 1'b1);
    applyStimulus(rowOf4(2000, 7, -2000, 8), 1'b1);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    checkOutput("t6_pre_en", ub_if.ub_wr_en, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    checkOutput("t6_wr_en", ub_if.ub_wr_en, 1'b0);
    checkOutput("t6_busy", busy, 1'b0);
    checkOutput("t6_sat", sat_count, 0);
    @(posedge clk);
    #1;
    ub_if.ub_wr_ready = 1'b1;
    startJob(100, 2, 1, 0, 0);
    applyStimulus(randomRow(), 1'b1);
    applyStimulus(randomRow(), 1'b1);
    waitDone(30, "t6_done");
    checkOutput("t6_writes", job_writes, 2);

    repeat (5) @(posedge clk);
    #1;
    checkOutput("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
